// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register. It bypasses the writeback value past the register file,
// turns a load-use hazard or a flush into a bubble, and counts stall cycles with saturation.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [ADDR_W-1:0] ex_rs1,
  output logic [ADDR_W-1:0] ex_rs2,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic              stall_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              mem_read_q, mem_read_d;
  logic              reg_write_q, reg_write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              hazard;
  logic              bubble;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // The register file cannot show a same-cycle write, so a matching writeback is forwarded.
  // x0 always reads zero, and a writeback addressed to x0 is never forwarded.
  always_comb begin
    op_a = id_rd1;
    if (id_rs1 == '0) begin
      op_a = '0;
    end else if (wb_we && (wb_addr != '0) && (wb_addr == id_rs1)) begin
      op_a = wb_data;
    end

    op_b = id_rd2;
    if (id_rs2 == '0) begin
      op_b = '0;
    end else if (wb_we && (wb_addr != '0) && (wb_addr == id_rs2)) begin
      op_b = wb_data;
    end
  end

  // Both rs fields are compared whether or not the instruction uses them.
  assign hazard = id_valid & valid_q & mem_read_q & (rd_q != '0)
                & ((rd_q == id_rs1) | (rd_q == id_rs2));
  assign stall_id = hazard & ~flush;
  assign bubble   = flush | hazard;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    if (bubble) begin
      // The data fields keep their old contents; only the control that can cause effects is cleared.
      valid_d     = 1'b0;
      ctrl_d      = '0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      a_d         = op_a;
      b_d         = op_b;
      imm_d       = id_imm;
      ctrl_d      = id_ctrl;
      mem_read_d  = id_valid & id_mem_read;
      reg_write_d = id_valid & id_reg_write;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_id && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_a         = a_q;
  assign ex_b         = b_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: a driver pushes hand-computed EX contents into a queue,
// and a monitor pops and compares one entry after every rising edge that has one pending.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        mr;
    logic        rw;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic        mr;
    logic        rw;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
  } in_t;

  localparam int EXP_W = $bits(exp_t);

  logic              clock;
  logic              reset_n;
  logic              id_valid, id_mem_read, id_reg_write;
  logic [31:0]       id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [15:0]       id_ctrl;
  logic              wb_we, flush;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;

  logic              ex_valid, ex_mem_read, ex_reg_write, stall_id;
  logic [31:0]       ex_pc, ex_a, ex_b, ex_imm, stall_cnt;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [15:0]       ex_ctrl;

  logic              s_ex_valid, s_ex_mem_read, s_ex_reg_write, s_stall_id;
  logic [31:0]       s_ex_pc, s_ex_a, s_ex_b, s_ex_imm;
  logic [4:0]        s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [15:0]       s_ex_ctrl;
  logic [3:0]        s_stall_cnt;

  logic [EXP_W-1:0]  exp_q[$];
  int                checks = 0;
  int                passed = 0;

  id_ex_stage dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
    .ex_a(s_ex_a), .ex_b(s_ex_b), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
    .ex_mem_read(s_ex_mem_read), .ex_reg_write(s_ex_reg_write), .stall_id(s_stall_id),
    .stall_cnt(s_stall_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  function automatic in_t mk_id(input logic v, input logic mr, input logic rw,
                                input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [15:0] ctrl);
    in_t t;
    t = '0;
    t.valid = v; t.mr = mr; t.rw = rw; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.rd1 = rd1; t.rd2 = rd2; t.imm = imm; t.ctrl = ctrl;
    return t;
  endfunction

  function automatic exp_t mk_exp(input logic v, input logic mr, input logic rw,
                                  input logic [31:0] pc, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic [15:0] ctrl,
                                  input logic [31:0] cnt);
    exp_t e;
    e.valid = v; e.mr = mr; e.rw = rw; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.a = a; e.b = b; e.imm = imm; e.ctrl = ctrl; e.cnt = cnt;
    e.cnt4 = (cnt > 32'd15) ? 4'd15 : cnt[3:0];
    return e;
  endfunction

  // driver tasks
  task automatic apply(input in_t t, input logic exp_stall, input exp_t e);
    id_valid = t.valid; id_mem_read = t.mr; id_reg_write = t.rw; id_pc = t.pc;
    id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd; id_rd1 = t.rd1; id_rd2 = t.rd2;
    id_imm = t.imm; id_ctrl = t.ctrl; wb_we = t.wb_we; wb_addr = t.wb_addr;
    wb_data = t.wb_data; flush = t.flush;
    #1;
    chk("stall_id", {31'd0, stall_id}, {31'd0, exp_stall});
    exp_q.push_back(EXP_W'(e));
    @(posedge clock);
  endtask

  task automatic vec(input in_t t, input logic exp_stall, input exp_t e);
    @(negedge clock);
    apply(t, exp_stall, e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_ex_pc"}, ex_pc, 32'd0);
    chk({tag, "_ex_rs1"}, {27'd0, ex_rs1}, 32'd0);
    chk({tag, "_ex_rs2"}, {27'd0, ex_rs2}, 32'd0);
    chk({tag, "_ex_rd"}, {27'd0, ex_rd}, 32'd0);
    chk({tag, "_ex_a"}, ex_a, 32'd0);
    chk({tag, "_ex_b"}, ex_b, 32'd0);
    chk({tag, "_ex_imm"}, ex_imm, 32'd0);
    chk({tag, "_ex_ctrl"}, {16'd0, ex_ctrl}, 32'd0);
    chk({tag, "_ex_mem_read"}, {31'd0, ex_mem_read}, 32'd0);
    chk({tag, "_ex_reg_write"}, {31'd0, ex_reg_write}, 32'd0);
    chk({tag, "_stall_id"}, {31'd0, stall_id}, 32'd0);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, "_stall_cnt4"}, {28'd0, s_stall_cnt}, 32'd0);
  endtask

  // scoreboard monitor
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
      chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
      chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
      chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
      chk("ex_a", ex_a, e.a);
      chk("ex_b", ex_b, e.b);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
      chk("stall_cnt", stall_cnt, e.cnt);
      chk("stall_cnt4", {28'd0, s_stall_cnt}, {28'd0, e.cnt4});
    end
  end

  initial begin
    in_t t;
    reset_n = 1'b0;
    t = '0;
    id_valid = 0; id_mem_read = 0; id_reg_write = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0;
    id_rd = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_ctrl = 0; wb_we = 0; wb_addr = 0;
    wb_data = 0; flush = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // pass-through
    t = mk_id(1, 0, 1, 32'h100, 3, 4, 6, 32'h11, 32'h22, 32'h7, 16'h00A5);
    vec(t, 0, mk_exp(1, 0, 1, 32'h100, 3, 4, 6, 32'h11, 32'h22, 32'h7, 16'h00A5, 0));
    // writeback bypass onto A, then onto B
    t.pc = 32'h104; t.wb_we = 1; t.wb_addr = 3; t.wb_data = 32'hABCD;
    vec(t, 0, mk_exp(1, 0, 1, 32'h104, 3, 4, 6, 32'hABCD, 32'h22, 32'h7, 16'h00A5, 0));
    t.pc = 32'h108; t.wb_addr = 4; t.wb_data = 32'h5555;
    vec(t, 0, mk_exp(1, 0, 1, 32'h108, 3, 4, 6, 32'h11, 32'h5555, 32'h7, 16'h00A5, 0));
    // x0 source and a writeback to x0
    t.pc = 32'h10C; t.rs1 = 0; t.rd1 = 32'h99; t.wb_addr = 0; t.wb_data = 32'hDEAD;
    vec(t, 0, mk_exp(1, 0, 1, 32'h10C, 0, 4, 6, 32'h0, 32'h22, 32'h7, 16'h00A5, 0));
    // address match without write enable
    t.pc = 32'h110; t.rs1 = 3; t.rd1 = 32'h11; t.wb_we = 0; t.wb_addr = 3;
    vec(t, 0, mk_exp(1, 0, 1, 32'h110, 3, 4, 6, 32'h11, 32'h22, 32'h7, 16'h00A5, 0));
    // invalid slot: fields load, write and load flags forced low
    t = mk_id(0, 1, 1, 32'h114, 7, 8, 9, 32'h77, 32'h88, 32'h3, 16'h1234);
    vec(t, 0, mk_exp(0, 0, 0, 32'h114, 7, 8, 9, 32'h77, 32'h88, 32'h3, 16'h1234, 0));
    // load then dependent use: one stall, then retry with the load result on writeback
    t = mk_id(1, 1, 1, 32'h118, 1, 2, 5, 32'h1000, 32'h2000, 32'h10, 16'h0F0F);
    vec(t, 0, mk_exp(1, 1, 1, 32'h118, 1, 2, 5, 32'h1000, 32'h2000, 32'h10, 16'h0F0F, 0));
    t = mk_id(1, 0, 1, 32'h11C, 6, 5, 7, 32'h60, 32'h50, 32'h4, 16'h00CC);
    vec(t, 1, mk_exp(0, 0, 0, 32'h118, 1, 2, 5, 32'h1000, 32'h2000, 32'h10, 16'h0000, 1));
    t.wb_we = 1; t.wb_addr = 5; t.wb_data = 32'hBEEF;
    vec(t, 0, mk_exp(1, 0, 1, 32'h11C, 6, 5, 7, 32'h60, 32'hBEEF, 32'h4, 16'h00CC, 1));
    // hazard together with flush: no stall, bubble, counter unchanged
    t = mk_id(1, 1, 1, 32'h120, 2, 3, 8, 32'h200, 32'h300, 32'h20, 16'h0101);
    vec(t, 0, mk_exp(1, 1, 1, 32'h120, 2, 3, 8, 32'h200, 32'h300, 32'h20, 16'h0101, 1));
    t = mk_id(1, 0, 1, 32'h124, 8, 9, 10, 32'h800, 32'h900, 32'h1, 16'h0202);
    t.flush = 1;
    vec(t, 0, mk_exp(0, 0, 0, 32'h120, 2, 3, 8, 32'h200, 32'h300, 32'h20, 16'h0000, 1));
    t = mk_id(1, 0, 0, 32'h200, 8, 8, 0, 32'h1, 32'h2, 32'h0, 16'h0303);
    vec(t, 0, mk_exp(1, 0, 0, 32'h200, 8, 8, 0, 32'h1, 32'h2, 32'h0, 16'h0303, 1));
    // a load to x0 never raises a hazard
    t = mk_id(1, 1, 1, 32'h204, 1, 1, 0, 32'hA, 32'hB, 32'h0, 16'h0404);
    vec(t, 0, mk_exp(1, 1, 1, 32'h204, 1, 1, 0, 32'hA, 32'hB, 32'h0, 16'h0404, 1));
    t = mk_id(1, 0, 1, 32'h208, 0, 0, 3, 32'h5, 32'h6, 32'h0, 16'h0505);
    vec(t, 0, mk_exp(1, 0, 1, 32'h208, 0, 0, 3, 32'h0, 32'h0, 32'h0, 16'h0505, 1));
    // back-to-back dependent loads stall one cycle each
    t = mk_id(1, 1, 1, 32'h20C, 5, 6, 5, 32'h11, 32'h22, 32'h8, 16'h0606);
    vec(t, 0, mk_exp(1, 1, 1, 32'h20C, 5, 6, 5, 32'h11, 32'h22, 32'h8, 16'h0606, 1));
    t = mk_id(1, 1, 1, 32'h210, 5, 0, 9, 32'h33, 32'h0, 32'h4, 16'h0707);
    vec(t, 1, mk_exp(0, 0, 0, 32'h20C, 5, 6, 5, 32'h11, 32'h22, 32'h8, 16'h0000, 2));
    vec(t, 0, mk_exp(1, 1, 1, 32'h210, 5, 0, 9, 32'h33, 32'h0, 32'h4, 16'h0707, 2));
    t = mk_id(1, 0, 1, 32'h214, 1, 9, 2, 32'h44, 32'h55, 32'h0, 16'h0808);
    vec(t, 1, mk_exp(0, 0, 0, 32'h210, 5, 0, 9, 32'h33, 32'h0, 32'h4, 16'h0000, 3));
    vec(t, 0, mk_exp(1, 0, 1, 32'h214, 1, 9, 2, 32'h44, 32'h55, 32'h0, 16'h0808, 3));

    // reset asserted between edges with the pipeline full
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clock);
    #1;
    chk_all_zero("held_reset");
    @(negedge clock);
    reset_n = 1'b1;
    t = mk_id(0, 0, 0, 32'h300, 1, 2, 3, 32'hAA, 32'hBB, 32'hC, 16'h0909);
    apply(t, 0, mk_exp(0, 0, 0, 32'h300, 1, 2, 3, 32'hAA, 32'hBB, 32'hC, 16'h0909, 0));

    // a self-dependent load held in ID stalls every other cycle; the 4-bit counter saturates
    t = mk_id(1, 1, 1, 32'h400, 5, 5, 5, 32'h0, 32'h0, 32'h0, 16'h0A0A);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 1)
        vec(t, 1, mk_exp(0, 0, 0, 32'h400, 5, 5, 5, 0, 0, 0, 16'h0000, 32'((i + 1) / 2)));
      else
        vec(t, 0, mk_exp(1, 1, 1, 32'h400, 5, 5, 5, 0, 0, 0, 16'h0A0A, 32'((i + 1) / 2)));
    end

    repeat (2) @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
